// File: rtl/input_buffer_if.sv
// input_buffer_if: flit path from upstream into the input buffer and from the buffer to the switch.
interface input_buffer_if #(parameter int TAM_FLIT = 16);
  logic                rx;
  logic [TAM_FLIT-1:0] data_in;
  logic                credit_o;
  logic                h;
  logic                ack_h;
  logic                data_av;
  logic [TAM_FLIT-1:0] data;
  logic                data_ack;
  logic                sender;
  modport master (output rx, data_in, ack_h, data_ack, input credit_o, h, data_av, data, sender);
  modport slave  (input rx, data_in, ack_h, data_ack, output credit_o, h, data_av, data, sender);
endinterface

// File: rtl/input_buffer.sv
// input_buffer: circular flit FIFO with a packet-framing FSM that requests a route and streams header, size and payload.
// Define BUFFER_OCCUPANCY_EN to add the occupancy output.
module input_buffer #(
  parameter int TAM_FLIT   = 16,
  parameter int TAM_BUFFER = 16
) (
  input  logic                         clock,
  input  logic                         reset,
`ifdef BUFFER_OCCUPANCY_EN
  output logic [$clog2(TAM_BUFFER):0]  occupancy,
`endif
  input_buffer_if.slave                bus
);
  localparam int PW = $clog2(TAM_BUFFER);
  localparam logic [PW:0] DEPTH = (PW+1)'(TAM_BUFFER);
  typedef enum logic [2:0] {IDLE, HEADER, SEND_HDR, SEND_SIZE, PAYLOAD, END} state_t;
  state_t              state_q, state_d;
  logic [TAM_FLIT-1:0] mem_q [TAM_BUFFER];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]         count_q, count_d;
  logic [TAM_FLIT-1:0] flit_cnt_q, flit_cnt_d;
  logic                h_q, h_d, sender_q, sender_d;
  logic                full, empty, push, pop, sending;
  assign full         = count_q == DEPTH;
  assign empty        = count_q == '0;
  assign sending      = state_q inside {SEND_HDR, SEND_SIZE, PAYLOAD};
  assign push         = bus.rx && !full;
  assign pop          = bus.data_av && bus.data_ack;
  assign bus.credit_o = !full;
  assign bus.data_av  = sending && !empty;
  assign bus.data     = mem_q[rd_ptr_q];
  assign bus.h        = h_q;
  assign bus.sender   = sender_q;
`ifdef BUFFER_OCCUPANCY_EN
  assign occupancy    = count_q;
`endif
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
    state_d    = state_q;
    flit_cnt_d = flit_cnt_q;
    case (state_q)
      IDLE:      state_d = empty ? IDLE : HEADER;
      HEADER:    state_d = bus.ack_h ? SEND_HDR : HEADER;
      SEND_HDR:  state_d = pop ? SEND_SIZE : SEND_HDR;
      SEND_SIZE: if (pop) begin
        flit_cnt_d = bus.data;
        state_d    = bus.data == '0 ? END : PAYLOAD;
      end
      PAYLOAD:   if (pop) begin
        flit_cnt_d = flit_cnt_q - TAM_FLIT'(1);
        state_d    = flit_cnt_q == TAM_FLIT'(1) ? END : PAYLOAD;
      end
      default:   state_d = IDLE;
    endcase
    // h rises one cycle into HEADER and drops on the edge that takes the grant
    h_d      = state_q == HEADER && state_d == HEADER;
    sender_d = state_d inside {SEND_HDR, SEND_SIZE, PAYLOAD};
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      flit_cnt_q <= '0;
      h_q        <= 1'b0;
      sender_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flit_cnt_q <= flit_cnt_d;
      h_q        <= h_d;
      sender_q   <= sender_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_in;
  end
endmodule

// File: tb/tb_input_buffer.sv
// tb_input_buffer: directed checks of framing, fill/credit, wrap, stall and async reset of input_buffer.
module tb_input_buffer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int          n_chk = 0;
  int          n_pass = 0;
  int          wi, ri;
  logic [15:0] exp_q [64];
  input_buffer_if #(.TAM_FLIT(16)) bus();
`ifdef BUFFER_OCCUPANCY_EN
  logic [4:0] occupancy;
`endif
  input_buffer #(.TAM_FLIT(16), .TAM_BUFFER(16)) dut (
    .clock(clock),
    .reset(reset),
`ifdef BUFFER_OCCUPANCY_EN
    .occupancy(occupancy),
`endif
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic stream(input int push_to, input int pop_to);
    int budget = 0;
    while (ri < pop_to && budget < 200) begin
      bus.ack_h    = bus.h;
      bus.data_ack = 1'b1;
      if (bus.data_av) begin
        check($sformatf("order%0d", ri), {16'h0, bus.data}, {16'h0, exp_q[ri]});
        ri++;
      end
      bus.rx      = wi < push_to;
      bus.data_in = exp_q[wi];
      if (bus.rx && bus.credit_o) wi++;
      tick();
      budget++;
    end
    bus.rx    = 1'b0;
    bus.ack_h = 1'b0;
    check("stream_done", ri, pop_to);
  endtask
  initial begin
    int k;
    bus.rx = 1'b0; bus.data_in = '0; bus.ack_h = 1'b0; bus.data_ack = 1'b0;
    #2;
    check("rst_credit", bus.credit_o, 1);
    check("rst_h", bus.h, 0);
    check("rst_dav", bus.data_av, 0);
    check("rst_sender", bus.sender, 0);
`ifdef BUFFER_OCCUPANCY_EN
    check("rst_occ", occupancy, 0);
`endif
    tick(); tick();
    reset = 1'b0;
    // basic packet, 2-cycle header latency
    bus.rx = 1'b1; bus.data_in = 16'h0011; tick();
    check("lat_e1_h", bus.h, 0);
    bus.data_in = 16'h0002; tick();
    check("lat_e2_h", bus.h, 0);
    bus.data_in = 16'hAAAA; tick();
    check("lat_h", bus.h, 1);
    check("hdr_dav", bus.data_av, 0);
    bus.data_in = 16'hBBBB; bus.ack_h = 1'b1; bus.data_ack = 1'b1; tick();
    bus.rx = 1'b0; bus.ack_h = 1'b0;
    check("h_fall", bus.h, 0);
    exp_q[0] = 16'h0011; exp_q[1] = 16'h0002; exp_q[2] = 16'hAAAA; exp_q[3] = 16'hBBBB;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("p1_dav%0d", i), bus.data_av, 1);
      check($sformatf("p1_snd%0d", i), bus.sender, 1);
      check($sformatf("p1_data%0d", i), {16'h0, bus.data}, {16'h0, exp_q[i]});
      tick();
    end
    check("p1_end_snd", bus.sender, 0);
    check("p1_end_dav", bus.data_av, 0);
    tick();
    check("p1_idle_h", bus.h, 0);
    // fill to full, overflow ignored
    bus.data_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q[i] = (i == 0) ? 16'h0033 : (i == 1) ? 16'h000E : 16'h1000 + 16'(i - 2);
      bus.rx = 1'b1; bus.data_in = exp_q[i]; tick();
      if (i == 14) check("fill15_credit", bus.credit_o, 1);
    end
    check("full_credit", bus.credit_o, 0);
`ifdef BUFFER_OCCUPANCY_EN
    check("full_occ", occupancy, 16);
`endif
    bus.data_in = 16'hDEAD; tick();
    bus.rx = 1'b0;
    check("ovf_credit", bus.credit_o, 0);
    check("ovf_h", bus.h, 1);
    bus.ack_h = 1'b1; tick();
    bus.ack_h = 1'b0;
    check("full_head", {16'h0, bus.data}, 32'h0033);
    bus.data_ack = 1'b1; tick();
    check("pop_credit", bus.credit_o, 1);
    check("pop_next", {16'h0, bus.data}, 32'h000E);
    wi = 16; ri = 1;
    stream(16, 16);
    check("fill_end_snd", bus.sender, 0);
    tick(); tick(); tick();
    check("ovf_dropped", bus.h, 0);
    // zero-length packet then queued header
    exp_q[0] = 16'h0022; exp_q[1] = 16'h0000; exp_q[2] = 16'h0044; exp_q[3] = 16'h0001; exp_q[4] = 16'h0055;
    bus.data_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.rx = 1'b1; bus.data_in = exp_q[i]; tick();
    end
    bus.rx = 1'b0;
    k = 0;
    while (!bus.h && k < 20) begin tick(); k++; end
    check("z_hwait", bus.h, 1);
    bus.ack_h = 1'b1; bus.data_ack = 1'b1; tick();
    bus.ack_h = 1'b0;
    check("z_hdr", {16'h0, bus.data}, 32'h0022);
    tick();
    check("z_size", {15'h0, bus.data_av, bus.data}, 32'h10000);
    tick();
    check("z_end_snd", bus.sender, 0);
    check("z_end_dav", bus.data_av, 0);
    tick();
    check("z_idle_h", bus.h, 0);
    tick();
    check("z_hdr1_h", bus.h, 0);
    tick();
    check("z_h2", bus.h, 1);
    wi = 5; ri = 2;
    stream(5, 5);
    check("z2_end_snd", bus.sender, 0);
    // streaming across pointer wrap
    for (int i = 0; i < 26; i++)
      exp_q[i] = (i == 0) ? 16'h0066 : (i == 1) ? 16'h0018 : 16'h2000 + 16'(i - 2);
    wi = 0; ri = 0;
    stream(26, 26);
    check("wrap_end_snd", bus.sender, 0);
    check("wrap_credit", bus.credit_o, 1);
    // upstream stall mid-payload
    exp_q[0] = 16'h0077; exp_q[1] = 16'h0003;
    exp_q[2] = 16'h3000; exp_q[3] = 16'h3001; exp_q[4] = 16'h3002;
    wi = 0; ri = 0;
    stream(3, 3);
    check("stall_dav", bus.data_av, 0);
    check("stall_snd", bus.sender, 1);
    tick(); tick(); tick();
    check("stall_hold_dav", bus.data_av, 0);
    check("stall_hold_snd", bus.sender, 1);
    stream(5, 5);
    check("stall_end_snd", bus.sender, 0);
    // async reset mid-payload
    exp_q[0] = 16'h0088; exp_q[1] = 16'h0004;
    for (int i = 2; i < 6; i++) exp_q[i] = 16'h5000 + 16'(i - 2);
    wi = 0; ri = 0;
    stream(4, 3);
    check("pre_rst_dav", bus.data_av, 1);
    check("pre_rst_snd", bus.sender, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_h", bus.h, 0);
    check("arst_dav", bus.data_av, 0);
    check("arst_snd", bus.sender, 0);
    check("arst_credit", bus.credit_o, 1);
    #1 reset = 1'b0;
    tick(); tick(); tick();
    check("post_rst_h", bus.h, 0);
    exp_q[0] = 16'h0099; exp_q[1] = 16'h0001; exp_q[2] = 16'h6000;
    wi = 0; ri = 0;
    stream(3, 3);
    check("fresh_end_snd", bus.sender, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
